// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
// The master side is the sequencer; the slave side supplies lock and relock requests.
interface pll_reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int RETRY_W     = 2
);
  logic                   pll_locked;
  logic                   relock_req;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst;
  logic                   ready;
  logic                   fault;
  logic [2:0]             state;
  logic [RETRY_W-1:0]     retry_cnt;
  logic [7:0]             lock_loss_count;

  modport master (
    input  pll_locked, relock_req,
    output pll_rst, domain_rst, ready, fault, state, retry_cnt, lock_loss_count
  );

  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, domain_rst, ready, fault, state, retry_cnt, lock_loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Power-up / relock sequencer for the fabric PLL and its staggered domain resets.
// state     | meaning
// RESET_PLL | hold PLL reset for RST_PULSE_CYCLES
// WAIT_LOCK | wait for synchronized lock, bounded by LOCK_TIMEOUT_CYCLES
// STABLE    | lock must hold for LOCK_STABLE_CYCLES
// RELEASE   | clear domain resets one by one, DOMAIN_STAGGER apart
// RUN       | all domains out of reset, ready
// FAULT     | retries exhausted, sticky until rst or relock_req
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 3,
  parameter int NUM_DOMAINS         = 4,
  parameter int DOMAIN_STAGGER      = 8
) (
  input logic refclk,
  input logic rst,
  pll_reset_sequencer_if.master bus
);
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES),
                                max2(LOCK_TIMEOUT_CYCLES, NUM_DOMAINS * DOMAIN_STAGGER));
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RETRY_W = max2($clog2(MAX_RETRIES + 1), 2);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [7:0]             llc_q, llc_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic                   sync1_q, locked_s;
  logic                   fail, abort;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1_q  <= bus.pll_locked;
      locked_s <= sync1_q;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      llc_q     <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      llc_q     <= llc_d;
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    llc_d   = llc_q;
    fail    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == CNT_W'(RST_PULSE_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          fail = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          fail = 1'b1;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (!locked_s || bus.relock_req) begin
          abort = 1'b1;
        end else if (cnt_q == CNT_W'((NUM_DOMAINS - 1) * DOMAIN_STAGGER)) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!locked_s || bus.relock_req) abort = 1'b1;
      end
      FAULT: begin
        cnt_d = cnt_q;
        if (bus.relock_req) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    if (fail) begin
      cnt_d = '0;
      if (retry_q == RETRY_W'(MAX_RETRIES)) begin
        state_d = FAULT;
      end else begin
        state_d = RESET_PLL;
        retry_d = retry_q + 1'b1;
      end
    end

    // a lock loss that coincides with relock_req is still counted
    if (abort) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      if (!locked_s && llc_q != 8'hFF) llc_d = llc_q + 8'd1;
    end
  end

  // outputs are registered from the next state so they line up with it
  always_comb begin
    pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
    dom_d     = '1;
    if (state_d == RELEASE) begin
      dom_d = dom_q;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        if (cnt_d == CNT_W'(i * DOMAIN_STAGGER)) dom_d[i] = 1'b0;
      end
    end else if (state_d == RUN) begin
      dom_d = '0;
    end
  end

  assign bus.pll_rst         = pll_rst_q;
  assign bus.domain_rst      = dom_q;
  assign bus.ready           = ready_q;
  assign bus.fault           = fault_q;
  assign bus.state           = state_q;
  assign bus.retry_cnt       = retry_q;
  assign bus.lock_loss_count = llc_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues every expected output change with its cycle,
// a monitor pops and compares whenever the DUT outputs change.
module tb_pll_reset_sequencer;
  logic refclk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  pll_reset_sequencer_if #(.NUM_DOMAINS(4), .RETRY_W(2)) bus ();

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (3),
    .NUM_DOMAINS        (4),
    .DOMAIN_STAGGER     (2)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       prst;
    logic [3:0] dom;
    logic       rdy;
    logic       flt;
    logic [1:0] rc;
    logic [7:0] llc;
  } snap_t;

  snap_t exp_q[$];
  int    exp_c[$];
  snap_t cur, prv, e;
  int    ec;
  bit    have_prv;

  localparam snap_t RST_VEC = '{st: 3'd0, prst: 1'b1, dom: 4'hF, rdy: 1'b0,
                                flt: 1'b0, rc: 2'd0, llc: 8'd0};

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  initial cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  function automatic snap_t mk(input logic [2:0] st, input logic prst, input logic [3:0] dom,
                               input logic rdy, input logic flt, input logic [1:0] rc,
                               input logic [7:0] llc);
    snap_t s;
    s.st = st; s.prst = prst; s.dom = dom; s.rdy = rdy; s.flt = flt; s.rc = rc; s.llc = llc;
    return s;
  endfunction

  task automatic push(input int t, input snap_t s);
    exp_q.push_back(s);
    exp_c.push_back(t);
  endtask

  // normal lock sequence starting with cnt=0 of RESET_PLL in cycle b; first n changes
  task automatic push_seq(input int b, input logic [1:0] r, input logic [7:0] l, input int n);
    int         off [7] = '{4, 5, 13, 15, 17, 19, 20};
    logic [3:0] dm  [7] = '{4'hF, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
    logic [2:0] st;
    for (int i = 0; i < n; i++) begin
      st = (i == 0) ? 3'd1 : (i == 1) ? 3'd2 : (i == 6) ? 3'd4 : 3'd3;
      push(b + off[i], mk(st, 1'b0, dm[i], i == 6, 1'b0, (i == 6) ? 2'd0 : r, l));
    end
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) @(negedge refclk);
  endtask

  initial begin
    have_prv = 1'b0;
    forever begin
      @(posedge refclk);
      #2;
      cur = mk(bus.state, bus.pll_rst, bus.domain_rst, bus.ready, bus.fault,
               bus.retry_cnt, bus.lock_loss_count);
      if (!have_prv || cur !== prv) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got st=%0d prst=%0b dom=%b rdy=%0b flt=%0b rc=%0d llc=%0d @cyc %0d, want no change",
                   cur.st, cur.prst, cur.dom, cur.rdy, cur.flt, cur.rc, cur.llc, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_c.pop_front();
          if (cur !== e || cyc != ec) begin
            n_fail++;
            $display("FAIL evt_%0d: got st=%0d prst=%0b dom=%b rdy=%0b flt=%0b rc=%0d llc=%0d @cyc %0d, want st=%0d prst=%0b dom=%b rdy=%0b flt=%0b rc=%0d llc=%0d @cyc %0d",
                     n_checks, cur.st, cur.prst, cur.dom, cur.rdy, cur.flt, cur.rc, cur.llc, cyc,
                     e.st, e.prst, e.dom, e.rdy, e.flt, e.rc, e.llc, ec);
          end
        end
      end
      prv      = cur;
      have_prv = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, j, b, c;
    n_checks = 0;
    n_fail   = 0;
    rst             = 1'b1;
    bus.pll_locked  = 1'b1;
    bus.relock_req  = 1'b0;
    push(1, RST_VEC);
    @(negedge refclk);

    // lock held high from power-up
    to_cyc(3);
    rst = 1'b0;
    t0  = cyc;
    push_seq(t0, 2'd0, 8'd0, 7);
    to_cyc(t0 + 24);

    // two-cycle lock drop in RUN
    j = cyc;
    bus.pll_locked = 1'b0;
    b = j + 3;
    push(b, mk(3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 8'd1));
    push_seq(b, 2'd0, 8'd1, 7);
    to_cyc(j + 2);
    bus.pll_locked = 1'b1;
    to_cyc(b + 24);

    // relock in RUN, then rst after domain 1 has cleared
    j = cyc;
    bus.relock_req = 1'b1;
    b = j + 1;
    push(b, mk(3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 8'd1));
    push_seq(b, 2'd0, 8'd1, 4);
    to_cyc(j + 1);
    bus.relock_req = 1'b0;
    to_cyc(b + 15);
    rst = 1'b1;
    push(b + 16, RST_VEC);
    to_cyc(b + 18);
    rst = 1'b0;
    t0  = cyc;

    // one-cycle lock glitch at STABLE cnt=5
    push_seq(t0, 2'd0, 8'd0, 2);
    to_cyc(t0 + 8);
    bus.pll_locked = 1'b0;
    b = t0 + 11;
    push(b, mk(3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd1, 8'd0));
    push_seq(b, 2'd1, 8'd0, 7);
    to_cyc(t0 + 9);
    bus.pll_locked = 1'b1;
    to_cyc(b + 24);

    // lock never arrives: four attempts then FAULT
    c = cyc;
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    push(c + 1, RST_VEC);
    to_cyc(c + 3);
    rst = 1'b0;
    t0  = cyc;
    for (int a = 0; a < 4; a++) begin
      push(t0 + 36 * a + 4, mk(3'd1, 1'b0, 4'hF, 1'b0, 1'b0, 2'(a), 8'd0));
      if (a < 3) push(t0 + 36 * a + 36, mk(3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'(a + 1), 8'd0));
      else       push(t0 + 144, mk(3'd5, 1'b1, 4'hF, 1'b0, 1'b1, 2'd3, 8'd0));
    end
    to_cyc(t0 + 150);

    // relock_req leaves FAULT
    bus.pll_locked = 1'b1;
    to_cyc(cyc + 4);
    j = cyc;
    bus.relock_req = 1'b1;
    b = j + 1;
    push(b, mk(3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0));
    push_seq(b, 2'd0, 8'd0, 7);
    to_cyc(j + 1);
    bus.relock_req = 1'b0;
    to_cyc(b + 24);

    // 300 lock losses: counter saturates at 255
    for (int n = 1; n <= 300; n++) begin
      j = cyc;
      bus.pll_locked = 1'b0;
      b = j + 3;
      push(b, mk(3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, (n > 255) ? 8'd255 : 8'(n)));
      push_seq(b, 2'd0, (n > 255) ? 8'd255 : 8'(n), 7);
      to_cyc(j + 2);
      bus.pll_locked = 1'b1;
      to_cyc(b + 21);
    end

    to_cyc(cyc + 5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected changes never seen, want 0", exp_q.size());
    end
    n_checks++;
    if (bus.lock_loss_count !== 8'd255) begin
      n_fail++;
      $display("FAIL llc_saturate: got %0d, want 255", bus.lock_loss_count);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
